// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN byte-stream loader.
package bnn_pkg;

  typedef enum logic [1:0] {
    PKT_IMG = 2'b00,
    PKT_C1  = 2'b01,
    PKT_C2  = 2'b10,
    PKT_FC  = 2'b11
  } pkt_t;

  localparam int IMG_BYTES = 98;
  localparam int W_BYTES   = 4;
  localparam int IMG_BITS  = 784;

  localparam logic [1:0] LAYER_C1 = 2'd1;
  localparam logic [1:0] LAYER_C2 = 2'd2;
  localparam logic [1:0] LAYER_FC = 2'd3;

  typedef logic [IMG_BITS-1:0] d_image_t;

  // Stream bytes are MSB-first; payload is LSB-first by pixel index.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bitrev8[i] = b[7-i];
  endfunction

endpackage

// File: rtl/bnn_img_deser.sv
// Owns the 784-bit payload: byte-wise image fill plus masked weight patches.
module bnn_img_deser
  import bnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [6:0] i_idx,
  input  logic [7:0] i_byte,
  input  logic       i_pwe,
  input  d_image_t   i_pmask,
  input  d_image_t   i_pval,
  output d_image_t   o_payload,
  output logic       o_done
);

  d_image_t r_payload;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_payload <= '0;
    end else if (i_pwe) begin
      r_payload <= (r_payload & ~i_pmask) | (i_pval & i_pmask);
    end else if (i_we) begin
      for (int k = 0; k < IMG_BYTES; k++)
        if (i_idx == 7'(k)) r_payload[8*k +: 8] <= bitrev8(i_byte);
    end
  end

  assign o_payload = r_payload;
  assign o_done    = i_we && (i_idx == 7'(IMG_BYTES-1));

endmodule

// File: rtl/bnn_stream_loader.sv
// Packet parser: image packets fill the payload, weight packets emit write strobes.
module bnn_stream_loader
  import bnn_pkg::*;
#(
  parameter int N_K1 = 90,
  parameter int N_K2 = 1080,
  parameter int N_FC = 10,
  parameter int bW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output d_image_t      payload,
  output logic          image_out_valid,
  input  logic          image_out_ready,
  output logic          kernel_out_valid,
  output logic [1:0]    kernel_layer,
  output logic [10:0]   kernel_addr,
  output logic [bW-1:0] kernel_offset,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_W_ADDR, S_W_OFF, S_W_BITS, S_IMG, S_IMG_HOLD} state_t;

  state_t        r_state;
  logic [6:0]    r_cnt;
  pkt_t          r_type;
  logic [10:0]   r_addr;
  logic [bW-1:0] r_off;
  logic [23:0]   r_w;
  logic          r_s_ready, r_img_vld, r_kvld, r_err;
  logic [1:0]    r_layer;
  logic [10:0]   r_kaddr;
  logic [bW-1:0] r_koff;

  logic          w_acc, w_in_range, w_last_w, w_pwe, w_img_we, w_done;
  logic [31:0]   w_w;
  d_image_t      w_pmask, w_pval;

  assign w_acc    = s_valid && r_s_ready;
  assign w_w      = {r_w, s_data};
  assign w_last_w = w_acc && (r_state == S_W_BITS) && (r_cnt == 7'(W_BYTES-1));
  assign w_pwe    = w_last_w && w_in_range;
  assign w_img_we = w_acc && (r_state == S_IMG);

  always_comb begin
    w_in_range = 1'b0;
    case (r_type)
      PKT_C1:  w_in_range = int'(r_addr) < N_K1;
      PKT_C2:  w_in_range = int'(r_addr) < N_K2;
      PKT_FC:  w_in_range = int'(r_addr) < N_FC;
      default: w_in_range = 1'b0;
    endcase
  end

  // conv kernels land as a 5x5 window at the image origin; fc rows fill pixels 0..19
  always_comb begin
    w_pmask = '0;
    w_pval  = '0;
    if (r_type == PKT_FC) begin
      for (int k = 0; k < 20; k++) begin
        w_pmask[k] = 1'b1;
        w_pval[k]  = w_w[31-k];
      end
    end else begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) begin
          w_pmask[28*i+j] = 1'b1;
          w_pval[28*i+j]  = w_w[31-(5*i+j)];
        end
    end
  end

  bnn_img_deser u_deser (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_img_we),
    .i_idx     (r_cnt),
    .i_byte    (s_data),
    .i_pwe     (w_pwe),
    .i_pmask   (w_pmask),
    .i_pval    (w_pval),
    .o_payload (payload),
    .o_done    (w_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_type    <= PKT_IMG;
      r_addr    <= '0;
      r_off     <= '0;
      r_w       <= '0;
      r_s_ready <= 1'b0;
      r_img_vld <= 1'b0;
      r_kvld    <= 1'b0;
      r_err     <= 1'b0;
      r_layer   <= '0;
      r_kaddr   <= '0;
      r_koff    <= '0;
    end else begin
      r_kvld <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_s_ready <= 1'b1;
          if (w_acc) begin
            if (s_data[5:3] != 3'b000) begin
              r_err <= 1'b1;
            end else begin
              r_type       <= pkt_t'(s_data[7:6]);
              r_addr[10:8] <= s_data[2:0];
              r_cnt        <= '0;
              r_state      <= (s_data[7:6] == PKT_IMG) ? S_IMG : S_W_ADDR;
            end
          end
        end
        S_W_ADDR: if (w_acc) begin
          r_addr[7:0] <= s_data;
          r_cnt       <= '0;
          r_state     <= S_W_OFF;
        end
        S_W_OFF: if (w_acc) begin
          r_off   <= bW'(s_data);
          r_cnt   <= '0;
          r_state <= S_W_BITS;
        end
        S_W_BITS: if (w_acc) begin
          if (w_last_w) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (w_in_range) begin
              r_kvld  <= 1'b1;
              r_layer <= r_type;
              r_kaddr <= r_addr;
              r_koff  <= r_off;
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_w   <= {r_w[15:0], s_data};
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_IMG: if (w_acc) begin
          if (w_done) begin
            r_cnt     <= '0;
            r_state   <= S_IMG_HOLD;
            r_img_vld <= 1'b1;
            r_s_ready <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_IMG_HOLD: if (image_out_ready) begin
          r_cnt     <= '0;
          r_state   <= S_IDLE;
          r_img_vld <= 1'b0;
          r_s_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready          = r_s_ready;
  assign image_out_valid  = r_img_vld;
  assign kernel_out_valid = r_kvld;
  assign kernel_layer     = r_layer;
  assign kernel_addr      = r_kaddr;
  assign kernel_offset    = r_koff;
  assign err              = r_err;

endmodule

// File: doc/bnn_stream_loader.md
# bnn_stream_loader

Byte-stream front end for the binarized MNIST classifier core. Accepts one 8-bit valid/ready stream carrying framed image and weight packets, and deserializes image packets into a 28x28 binary image presented with a valid/ready handshake. Weight packets become single-cycle conv1/conv2/FC weight-write strobes. Sits directly upstream of the classifier top and drives its image and kernel-load ports.

## Interface
- N_K1, 90, number of conv1 kernel slots (address range 0..N_K1-1)
- N_K2, 1080, number of conv2 kernel slots
- N_FC, 10, number of FC weight rows
- bW, 8, offset width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_ready  out  1  loader accepts byte
- payload  out  784  flattened image; bit index 28*row+col
- image_out_valid  out  1  payload holds a complete image
- image_out_ready  in  1  core accepted image
- kernel_out_valid  out  1  one-cycle weight-write strobe
- kernel_layer  out  2  1=conv1, 2=conv2, 3=fc
- kernel_addr  out  11  weight slot
- kernel_offset  out  bW  offset byte
- err  out  1  one-cycle protocol-error pulse

## Operation
- Byte accepted iff s_valid & s_ready.
- Header byte: [7:6] type (00 image, 01 conv1, 10 conv2, 11 fc); [5:3] reserved, must be 0; [2:0] addr[10:8]. For image packets, [2:0] are ignored.
- Bad header (reserved bits ≠ 0): byte dropped, err pulses, state stays IDLE.
- Image packet: header plus 98 bytes. Each byte is MSB first and row-major: byte k bit 7 is pixel index 8k.
- Weight packet: header, addr[7:0], offset, then 4 weight bytes W[31:0] (first byte = W[31:24]), 7 bytes total.
  - conv: W[31:7] carry the kernel row-major. W[31-(5i+j)] goes to payload[28i+j] for i,j in 0..4.
  - fc: W[31:12] go to payload[0:19].
  - All other payload bits are unchanged.
- Range check on the last byte: the packet is rejected if addr ≥ N_K1 (conv1), ≥ N_K2 (conv2) or ≥ N_FC (fc). A rejected packet is consumed with no strobe and err pulses.
- FSM states: IDLE, W_ADDR, W_OFF, W_BITS (byte_cnt 0..3), IMG (byte_cnt 0..97), IMG_HOLD.
  - IDLE -> IMG on type 00, or -> W_ADDR on types 01/10/11.
  - W_ADDR -> W_OFF -> W_BITS; W_BITS returns to IDLE after byte 3.
  - IMG -> IMG_HOLD after byte 97.
  - IMG_HOLD -> IDLE on image_out_ready.
- byte_cnt is 7 bits and clears on every state entry.

## Timing
- Reset values: s_ready=0 in the reset cycle, then 1. payload=0, image_out_valid=0, kernel_out_valid=0, kernel_layer=0, kernel_addr=0, kernel_offset=0, err=0. FSM goes to IDLE and byte_cnt=0.
- Reset mid-packet discards the partial packet. The first byte after reset is parsed as a header.
- s_ready=1 in every state except IMG_HOLD, so throughput is one byte per cycle. Back-to-back packets need no gap.
- Image path:
  - image_out_valid rises the cycle after byte 97 is accepted.
  - It holds, with payload stable, until the cycle image_out_ready=1. It falls the following cycle, and s_ready returns to 1 that same cycle.
  - If image_out_ready is already high, the hold lasts exactly one cycle.
- Weight path:
  - kernel_out_valid, layer, addr, offset and payload update the cycle after the 4th weight byte.
  - The strobe lasts exactly 1 cycle; no ready is used.
  - kernel_layer, addr and offset hold their last values after the strobe.
- err is registered and fires the cycle after the offending byte.
- s_valid dropping mid-packet stalls the FSM with no timeout.

## Structure
- Shared package `bnn_pkg`:
  - packet type encodings
  - IMG_BYTES=98, W_BYTES=4
  - layer codes
  - d_image_t
- One natural sub-module: `bnn_img_deser`, which writes byte k into payload[8k +: 8] and asserts done at byte 97. The FSM, range checks and weight packing stay in the top module.

## Test plan
- Reset check: hold rst=0 for 3 cycles -> all outputs 0; s_ready=1 the first cycle after release.
- conv1 write: bytes 40,05,3C,FF,FF,FF,80 -> one strobe with layer=1, addr=5, offset=0x3C; payload[28i+j]=1 for all i,j<5; no err.
- Image with backpressure: header 00 then 98 bytes of 0xAA, image_out_ready=0 for 10 cycles -> image_out_valid held and s_ready=0 for 10 cycles; payload[28r+c]=~c[0] at every pixel; s_ready returns to 1 the cycle after the ready handshake.
- fc write: bytes C0,09,7F,F0,00,0F,FF -> layer=3, addr=9, offset=0x7F, payload[0:3]=1, payload[4:19]=0; image bits beyond 19 unchanged.
- Range and header errors:
  - conv2 header 84, addr byte 38 (addr 1080) plus 5 more bytes -> err pulse, no strobe.
  - Byte 08 in IDLE -> err; the next byte is parsed as a header.
- Reset mid-image: rst=0 after 50 image bytes, then send the conv1 packet above -> correct strobe and no image_out_valid.
